memory_responder: RTL
=====================

// Module: memory_responder
// PURPOSE
//  Byte-addressed, big-endian data/instruction memory; the responder side of the ControlUnit
//  memory handshake (MOV, R_W, Type out; MOC back).
//  Latches each request, waits a programmable number of cycles, performs the access, then
//  holds MOC until the requester withdraws MOV (four-phase handshake).
//  Also reports misaligned or illegal-size accesses so the control unit can raise a trap.
// PARAMETERS
//  ADDR_WIDTH   9   byte-address bits actually decoded; depth = 2**ADDR_WIDTH bytes
//  WAIT_CYCLES  2   cycles spent in BUSY before MOC; legal range 0..15
// PORTS
//  Clk      in   1   clock; all state changes on the rising edge
//  Clr      in   1   reset; asynchronous, active-low
//  MOV      in   1   memory operation valid, driven by the control unit
//  R_W      in   1   1 = read, 0 = write
//  Type     in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  SE       in   1   read sign-extend (byte/halfword only); 0 = zero-extend
//  Address  in  32   byte address; bits above ADDR_WIDTH-1 ignored (address wraps)
//  DataIn   in  32   write data, right-justified (byte in [7:0], halfword in [15:0])
//  DataOut  out 32   read data, right-justified and extended per SE
//  MOC      out  1   memory operation complete
//  Err      out  1   request rejected (misaligned or Type=11); valid while MOC=1
// BEHAVIOUR
//  Reset (Clr=0, any time, asynchronous): state=IDLE, MOC=0, Err=0, DataOut=32'h0, counter=0.
//    Memory array is not cleared.
//    An in-flight write that has not reached ACK is dropped.
//  FSM states:
//    IDLE : MOC=0. On an edge with MOV=1, latch R_W, Type, SE, Address, DataIn.
//           -> BUSY if WAIT_CYCLES>0, else -> ACK.
//    BUSY : counter counts up. After WAIT_CYCLES edges -> ACK.
//           If MOV=0 on any BUSY edge -> IDLE (abort: no write, MOC never asserted).
//    ACK  : Access is performed on the entering edge.
//           MOC=1, and Err is valid, for as long as MOV=1. MOV=0 -> IDLE, where MOC=0 and Err=0.
//  Latency: MOV first sampled high at edge k -> MOC high after edge k+WAIT_CYCLES+1.
//    With WAIT_CYCLES=0, MOC rises after edge k+1.
//  Latched request: inputs that change after the latching edge have no effect on the current
//    access. A new request requires MOV to return low (IDLE) first.
//  Alignment: halfword requires Address[0]=0; word requires Address[1:0]=00.
//    A violation, or Type=11, gives Err=1, no array write, and DataOut unchanged.
//  Byte order: big-endian; the byte at address A is the most significant byte of the word at A.
//  Write: updates only the 1/2/4 addressed bytes. DataOut is unchanged.
//  Read: DataOut loads on the ACK entry edge and holds until the next successful read or reset.
//    Byte   : SE=1 -> {{24{b[7]}}, b}; SE=0 -> {24'h0, b}.
//    Halfword: SE=1 -> {{16{h[15]}}, h}; SE=0 -> {16'h0, h}.
//    Word   : SE ignored.
//  Wrap-around: the word at the top of the array plus 4 addresses byte 0. Upper address bits
//    are discarded, so 32'h0000_0200 aliases 32'h0 when ADDR_WIDTH=9.
//  Reset during ACK or BUSY returns to IDLE immediately. MOC falls without waiting for MOV.
//  Preload: array contents may be loaded from a hex file by the testbench ($readmemh).
//    No hardware init port.
// TESTING
//  1 Write word: Address=0x10, DataIn=0xDEADBEEF, Type=10, R_W=0. Then read word at 0x10
//    -> DataOut=0xDEADBEEF; read byte 0x10 -> 0x000000DE; read byte 0x13 -> 0x000000EF.
//  2 Sign extension: byte 0x80 stored at 0x20. Read SE=1 -> 0xFFFFFF80; SE=0 -> 0x00000080.
//    Halfword 0x8001 at 0x22, read SE=1 -> 0xFFFF8001.
//  3 Latency/handshake: WAIT_CYCLES=2, MOV rises before edge k -> MOC=1 after edge k+3.
//    MOC stays 1 while MOV is held 5 extra cycles; MOC=0 one edge after MOV falls.
//    Repeat with WAIT_CYCLES=0 -> MOC after edge k+1.
//  4 Misalign/illegal: word write to 0x11, halfword read at 0x21, Type=11 -> each gives
//    MOC=1, Err=1. Memory at 0x10..0x13 still reads 0xDEADBEEF; DataOut unchanged.
//  5 Abort and reset: MOV drops during BUSY of a write of 0x12345678 to 0x40 -> MOC never
//    rises and 0x40 keeps its old value. Clr=0 pulse mid-ACK -> MOC=0, DataOut=0 asynchronously;
//    earlier memory contents are retained.
//  6 Wrap: byte write 0xAA to 0x200 (ADDR_WIDTH=9) -> byte read at 0x000 returns 0x000000AA.

Source files
------------

// File: rtl/memory_responder.sv
// Byte-addressed big-endian memory responder for a four-phase MOV/MOC handshake.
// MOC rises WAIT_CYCLES+1 edges after MOV is first sampled and is held until MOV drops; MOV low in BUSY aborts the request.
// Backpressure is the handshake itself: a new request is latched only from IDLE, so MOV must return low first.
module memory_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        MOV,
  input  logic        R_W,
  input  logic [1:0]  Type,
  input  logic        SE,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    rw_q, se_q;
  logic [1:0]              type_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             din_q;
  logic [7:0]              mem [DEPTH];

  logic                    rw_e, se_e, bad_e, enter_ack;
  logic [1:0]              type_e;
  logic [31:0]             din_e, rd_word, rd_ext;
  logic [15:0]             rd_half;
  logic [7:0]              rd_byte;
  logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
  logic                    unused_addr;

  assign unused_addr = ^Address[31:ADDR_WIDTH];

  // With WAIT_CYCLES=0 the access happens on the latching edge, so the live inputs are used there.
  always_comb begin
    if (state == IDLE) begin
      rw_e   = R_W;
      se_e   = SE;
      type_e = Type;
      a0     = Address[ADDR_WIDTH-1:0];
      din_e  = DataIn;
    end else begin
      rw_e   = rw_q;
      se_e   = se_q;
      type_e = type_q;
      a0     = addr_q;
      din_e  = din_q;
    end
  end

  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);

  assign bad_e = (type_e == 2'b11) ||
                 ((type_e == 2'b01) && a0[0]) ||
                 ((type_e == 2'b10) && (a0[1:0] != 2'b00));

  assign rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};
  assign rd_half = rd_word[31:16];
  assign rd_byte = rd_word[31:24];

  always_comb begin
    case (type_e)
      2'b00:   rd_ext = {{24{se_e & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{se_e & rd_half[15]}}, rd_half};
      default: rd_ext = rd_word;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (MOV) state_nxt = (WAIT_CYCLES == 0) ? ACK : BUSY;
      end
      BUSY: begin
        if (!MOV) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ACK;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ACK: begin
        if (!MOV) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_ack = (state_nxt == ACK) && (state != ACK);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rw_q    <= 1'b0;
      se_q    <= 1'b0;
      type_q  <= 2'b00;
      addr_q  <= '0;
      din_q   <= 32'h0;
      DataOut <= 32'h0;
      MOC     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && MOV) begin
        rw_q   <= R_W;
        se_q   <= SE;
        type_q <= Type;
        addr_q <= Address[ADDR_WIDTH-1:0];
        din_q  <= DataIn;
      end
      if (enter_ack && rw_e && !bad_e) DataOut <= rd_ext;
      // MOC/Err are registered one edge after ACK entry; both drop on the edge that sees MOV low.
      MOC <= (state == ACK) && MOV;
      Err <= (state == ACK) && MOV && bad_e;
    end
  end

  // Array is never reset; Clr gating drops a write that would land while reset is asserted.
  always_ff @(posedge Clk) begin
    if (Clr && enter_ack && !rw_e && !bad_e) begin
      case (type_e)
        2'b00: mem[a0] <= din_e[7:0];
        2'b01: begin
          mem[a0] <= din_e[15:8];
          mem[a1] <= din_e[7:0];
        end
        default: begin
          mem[a0] <= din_e[31:24];
          mem[a1] <= din_e[23:16];
          mem[a2] <= din_e[15:8];
          mem[a3] <= din_e[7:0];
        end
      endcase
    end
  end

endmodule
